// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signals of the UART TX arbiter.
// master is the arbiter side, slave is the requester/transmitter side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [15:0]          uart_data;
    logic                 uart_send;
    logic                 uart_set;
    logic                 uart_busy;

    modport master (
        input  req_valid, req_data, uart_busy,
        output req_ready, uart_data, uart_send, uart_set
    );

    modport slave (
        output req_valid, req_data, uart_busy,
        input  req_ready, uart_data, uart_send, uart_set
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes and baud updates to one UART transmitter.
// Pending baud changes take priority over all requesters.
module uart_tx_arbiter #(
    parameter int          NUM_REQ      = 4,
    parameter logic [15:0] BAUD_DEFAULT = 16'h186a
) (
    input  logic        clk,
    input  logic        reset,
    uart_tx_arbiter_if.master bus,
    input  logic        cfg_wr,
    input  logic [15:0] cfg_baud,
    output logic [2:0]  grant_id,
    output logic        active,
    output logic [15:0] baud_cur
);

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        SEND,
        ACK,
        DONE
    } state_t;

    localparam logic [2:0] LAST = 3'(NUM_REQ - 1);

    state_t state, state_d;

    logic               cfg_pend;
    logic [15:0]        pend_val;
    logic [2:0]         rr_ptr;
    logic               sel_hit;
    logic [2:0]         sel_idx;
    logic               accept;
    logic [NUM_REQ-1:0] ready;
    logic [15:0]        data_q;
    logic               send_q;
    logic               set_q;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        int j;
        sel_hit = 1'b0;
        sel_idx = '0;
        j       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (bus.req_valid[j]) begin
                sel_hit = 1'b1;
                sel_idx = 3'(j);
            end
        end
    end

    always_comb begin
        state_d = state;
        ready   = '0;
        accept  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cfg_pend) begin
                    state_d = CFG;
                end else if (sel_hit) begin
                    ready[sel_idx] = 1'b1;
                    accept         = 1'b1;
                    state_d        = SEND;
                end
            end
            CFG:  state_d = IDLE;
            SEND: state_d = ACK;
            ACK:  if (bus.uart_busy) state_d = DONE;
            DONE: if (!bus.uart_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            send_q   <= 1'b0;
            set_q    <= 1'b0;
            data_q   <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
            cfg_pend <= 1'b0;
            pend_val <= '0;
            baud_cur <= BAUD_DEFAULT;
        end else begin
            send_q <= (state_d == SEND);
            set_q  <= (state_d == CFG);
            // A write landing in the CFG cycle survives for another pass.
            if (cfg_wr) begin
                pend_val <= cfg_baud;
                cfg_pend <= 1'b1;
            end else if (state == CFG) begin
                cfg_pend <= 1'b0;
            end
            if (accept) begin
                data_q   <= {8'h00, bus.req_data[{sel_idx, 3'b000} +: 8]};
                grant_id <= sel_idx;
                rr_ptr   <= (sel_idx == LAST) ? 3'd0 : sel_idx + 3'd1;
            end else if (state == IDLE && cfg_pend) begin
                data_q <= cfg_wr ? cfg_baud : pend_val;
            end
            if (state == CFG) baud_cur <= data_q;
        end
    end

    assign bus.req_ready = ready;
    assign bus.uart_data = data_q;
    assign bus.uart_send = send_q;
    assign bus.uart_set  = set_q;
    assign active        = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, directed corner cases,
// and a randomized run against a transaction-level reference model.
module tb_uart_tx_arbiter;

    localparam int          N  = 4;
    localparam logic [15:0] BD = 16'h186a;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_wr;
    logic [15:0] cfg_baud;
    logic [2:0]  grant_id;
    logic        active;
    logic [15:0] baud_cur;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .BAUD_DEFAULT(BD)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .cfg_wr   (cfg_wr),
        .cfg_baud (cfg_baud),
        .grant_id (grant_id),
        .active   (active),
        .baud_cur (baud_cur)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("send_set_excl", 32'(bus.uart_send & bus.uart_set), 0);
            chk("ready_onehot0", 32'($onehot0(bus.req_ready)), 1);
        end
    end

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic chk_rst(input string t);
        chk({t, "_ready"}, 32'(bus.req_ready), 0);
        chk({t, "_send"}, 32'(bus.uart_send), 0);
        chk({t, "_set"}, 32'(bus.uart_set), 0);
        chk({t, "_data"}, 32'(bus.uart_data), 0);
        chk({t, "_grant"}, 32'(grant_id), 0);
        chk({t, "_active"}, 32'(active), 0);
        chk({t, "_baud"}, 32'(baud_cur), 32'(BD));
    endtask

    task automatic wait_send(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.uart_send && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_send_seen"}, 32'(bus.uart_send), 1);
    endtask

    task automatic busy_pulse(input int len);
        @(posedge clk); #1 bus.uart_busy = 1'b1;
        repeat (len - 1) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1 bus.uart_busy = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (active && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_idle"}, 32'(active), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] v;
        logic [31:0]  d;
        logic [N-1:0] rdy;
        logic [2:0]   g;
        logic [7:0]   b;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int set_c, send_c, nset;
        logic [15:0] set_d;
        int m_ptr, m_pend, send_due, pick;
        logic [15:0] m_pv, m_baud, m_data;
        logic [2:0] m_grant;
        int tx_phase, tx_cnt;

        tbl[0] = '{4'b0100, 32'h11A52233, 4'b0100, 3'd2, 8'hA5};
        tbl[1] = '{4'b0011, 32'h44332211, 4'b0001, 3'd0, 8'h11};
        tbl[2] = '{4'b1001, 32'hC3000077, 4'b1000, 3'd3, 8'hC3};
        tbl[3] = '{4'b1111, 32'h8899AABB, 4'b0001, 3'd0, 8'hBB};
        tbl[4] = '{4'b0001, 32'h000000FE, 4'b0001, 3'd0, 8'hFE};
        tbl[5] = '{4'b0110, 32'h00123400, 4'b0010, 3'd1, 8'h34};
        tbl[6] = '{4'b0010, 32'h00005600, 4'b0010, 3'd1, 8'h56};

        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.uart_busy = 1'b0;
        cfg_wr        = 1'b0;
        cfg_baud      = '0;

        #12 chk_rst("rst");
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) chk_rst("post_rst");

        // busy glitch while idle must not start anything
        @(posedge clk); #1 bus.uart_busy = 1'b1;
        @(negedge clk) chk("glitch_active", 32'(active), 0);
        @(posedge clk); #1 bus.uart_busy = 1'b0;
        @(negedge clk) chk("glitch_send", 32'(bus.uart_send), 0);

        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            bus.req_valid = tbl[i].v;
            bus.req_data  = tbl[i].d;
            @(negedge clk) chk("tbl_ready", 32'(bus.req_ready), 32'(tbl[i].rdy));
            @(posedge clk); #1 bus.req_valid = '0;
            @(negedge clk);
            chk("tbl_send", 32'(bus.uart_send), 1);
            chk("tbl_data", 32'(bus.uart_data), {24'h0, tbl[i].b});
            chk("tbl_grant", 32'(grant_id), 32'(tbl[i].g));
            chk("tbl_active", 32'(active), 1);
            busy_pulse(2);
            @(negedge clk);
            @(negedge clk);
            chk("tbl_idle", 32'(active), 0);
            chk("tbl_hold", 32'(bus.uart_data), {24'h0, tbl[i].b});
        end

        // all requesters held valid: grants rotate 0,1,2,3,0
        do_reset();
        @(posedge clk); #1;
        bus.req_valid = 4'b1111;
        bus.req_data  = 32'h03020100;
        for (int k = 0; k < 5; k++) begin
            wait_send("rr");
            chk("rr_grant", 32'(grant_id), 32'(k % 4));
            chk("rr_data", 32'(bus.uart_data), 32'(k % 4));
            if (k == 4) begin
                @(posedge clk); #1 bus.req_valid = '0;
            end
            busy_pulse(3);
        end
        wait_idle("rr");

        // baud change arriving while the transmitter is busy
        @(posedge clk); #1;
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h00000042;
        wait_send("cfg1");
        @(posedge clk); #1 bus.req_valid = '0; bus.uart_busy = 1'b1;
        @(posedge clk); #1 cfg_wr = 1'b1; cfg_baud = 16'h0010;
        @(posedge clk); #1;
        cfg_wr        = 1'b0;
        bus.uart_busy = 1'b0;
        bus.req_valid = 4'b0010;
        bus.req_data  = 32'h00007700;
        set_c  = -1;
        send_c = -1;
        set_d  = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.uart_set && set_c < 0) begin
                set_c = i;
                set_d = bus.uart_data;
            end
            if (bus.uart_send && send_c < 0) send_c = i;
            if (send_c >= 0) break;
        end
        chk("cfg_set_seen", 32'(set_c >= 0), 1);
        chk("cfg_set_data", 32'(set_d), 32'h0010);
        chk("cfg_set_first", 32'(set_c >= 0 && send_c > set_c), 1);
        chk("cfg_baud_cur", 32'(baud_cur), 32'h0010);
        @(posedge clk); #1 bus.req_valid = '0;
        busy_pulse(1);
        wait_idle("cfg1");

        // two writes during busy collapse into one update
        @(posedge clk); #1;
        bus.req_valid = 4'b0100;
        bus.req_data  = 32'h00550000;
        wait_send("cfg2");
        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.uart_busy = 1'b1;
        cfg_wr        = 1'b1;
        cfg_baud      = 16'h0020;
        @(posedge clk); #1 cfg_baud = 16'h0030;
        @(posedge clk); #1 cfg_wr = 1'b0;
        @(posedge clk); #1 bus.uart_busy = 1'b0;
        nset  = 0;
        set_d = '0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.uart_set) begin
                nset++;
                set_d = bus.uart_data;
            end
        end
        chk("cfg2_nset", 32'(nset), 1);
        chk("cfg2_data", 32'(set_d), 32'h0030);
        chk("cfg2_baud_cur", 32'(baud_cur), 32'h0030);

        // reset while waiting for busy abandons the transfer
        @(posedge clk); #1;
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h000000EE;
        wait_send("rst_ack");
        @(posedge clk); #1 bus.req_valid = '0;
        @(negedge clk) chk("rst_ack_active", 32'(active), 1);
        reset = 1'b1;
        #1 chk_rst("rst_ack");
        @(posedge clk); #1 reset = 1'b0;
        nset = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.uart_send) nset++;
        end
        chk("rst_no_replay", 32'(nset), 0);

        // randomized run against the reference model
        do_reset();
        m_ptr    = 0;
        m_pend   = 0;
        m_pv     = '0;
        m_baud   = BD;
        m_data   = '0;
        m_grant  = '0;
        send_due = -1;
        tx_phase = 0;
        tx_cnt   = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            if (tx_phase == 1) begin
                if (tx_cnt == 0) begin
                    bus.uart_busy = 1'b1;
                    tx_phase      = 2;
                    tx_cnt        = $urandom_range(0, 3);
                end else tx_cnt--;
            end else if (tx_phase == 2) begin
                if (tx_cnt == 0) begin
                    bus.uart_busy = 1'b0;
                    tx_phase      = 0;
                end else tx_cnt--;
            end
            if (cyc < 2800) begin
                bus.req_valid = ($urandom_range(0, 3) == 0) ? '0 : 4'($urandom);
                bus.req_data  = $urandom;
                cfg_wr        = ($urandom_range(0, 15) == 0);
                cfg_baud      = 16'($urandom);
            end else begin
                bus.req_valid = '0;
                cfg_wr        = 1'b0;
            end
            @(negedge clk);
            chk("rnd_baud", 32'(baud_cur), 32'(m_baud));
            chk("rnd_grant", 32'(grant_id), 32'(m_grant));
            chk("rnd_send", 32'(bus.uart_send), 32'(send_due == cyc));
            if (bus.uart_set) begin
                chk("rnd_set_pend", 32'(m_pend), 1);
                chk("rnd_set_data", 32'(bus.uart_data), 32'(m_pv));
                m_data = m_pv;
                m_baud = m_pv;
            end else begin
                chk("rnd_data", 32'(bus.uart_data), 32'(m_data));
            end
            pick = rr_pick(bus.req_valid, m_ptr);
            if (m_pend != 0 || active) begin
                chk("rnd_ready_off", 32'(bus.req_ready), 0);
            end else begin
                chk("rnd_ready", 32'(bus.req_ready), (pick < 0) ? 0 : (1 << pick));
                if (pick >= 0) begin
                    m_data   = {8'h00, bus.req_data[8*pick +: 8]};
                    m_grant  = 3'(pick);
                    m_ptr    = (pick + 1) % N;
                    send_due = cyc + 1;
                end
            end
            if (cfg_wr) begin
                m_pv   = cfg_baud;
                m_pend = 1;
            end else if (bus.uart_set) begin
                m_pend = 0;
            end
            if (bus.uart_send) begin
                tx_phase = 1;
                tx_cnt   = $urandom_range(0, 2);
            end
        end
        chk("rnd_final_idle", 32'(active), 0);
        chk("rnd_final_pend", 32'(m_pend), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
